seq_bin2bcd: RTL and testbench

SEQ_BIN2BCD -- requirements
Module: seq_bin2bcd

---
 rtl/bcd_pkg.sv | 13 +
 rtl/seq_bin2bcd_add3.sv | 16 +
 rtl/seq_bin2bcd.sv | 114 +++++++++++
 tb/tb_seq_bin2bcd.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DIGITS = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } convState_t;

endpackage

// File: rtl/seq_bin2bcd_add3.sv
// Add-3 correction cell for one BCD digit: digits of 5 or more get +3 so the
// following left shift carries correctly into the next decade.
module B_add3BCD (
    input  logic [3:0] digitIn,
    output logic [3:0] digitOut
);

    // Correct a single digit ahead of the shift.
    always_comb begin
        digitOut = digitIn;
        if (digitIn >= 4'd5) begin
            digitOut = digitIn + 4'd3;
        end
    end

endmodule

// File: rtl/seq_bin2bcd.sv
// Sequential double-dabble converter: one correct-and-shift step per clock,
// WIDTH steps per conversion, result latched on the final step.
module seq_bin2bcd
    import bcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BCD_W = DIGITS * 4;
    localparam int SCR_W = BCD_W + WIDTH;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    convState_t        state;
    convState_t        stateNext;
    logic              accept;
    logic              lastStep;
    logic [BCD_W-1:0]  bcdAcc;
    logic [BCD_W-1:0]  bcdCorr;
    logic [WIDTH-1:0]  binSh;
    logic [CNT_W-1:0]  stepCnt;
    logic [SCR_W-1:0]  shifted;

    // One add-3 cell per decade of the accumulator.
    for (genvar g = 0; g < DIGITS; g++) begin : gDigit
        B_add3BCD uAdd3 (
            .digitIn  (bcdAcc[g*4 +: 4]),
            .digitOut (bcdCorr[g*4 +: 4])
        );
    end

    // Corrected scratch register shifted left by one; the top bit falls off.
    always_comb begin
        shifted = {bcdCorr, binSh} << 1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode and status outputs; start is only honoured in IDLE or DONE.
    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        lastStep  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    stateNext = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (stepCnt == LAST_STEP) begin
                    lastStep  = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    stateNext = SHIFT;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Scratch register, step counter and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcdAcc  <= '0;
            binSh   <= '0;
            stepCnt <= '0;
            bcd_out <= '0;
        end else if (accept) begin
            bcdAcc  <= '0;
            binSh   <= bin_in;
            stepCnt <= '0;
        end else if (state == SHIFT) begin
            bcdAcc <= shifted[SCR_W-1:WIDTH];
            binSh  <= shifted[WIDTH-1:0];
            if (lastStep) begin
                // Counter parks on its final value rather than wrapping.
                bcd_out <= shifted[SCR_W-1:WIDTH];
            end else begin
                stepCnt <= stepCnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Self-checking bench for seq_bin2bcd (WIDTH=8, DIGITS=3).
module tb_seq_bin2bcd;

    localparam int W = 8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;

    int vectors;
    int miscompares;

    seq_bin2bcd #(.WIDTH(8), .DIGITS(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal digits of v packed four bits per decade.
    function automatic logic [11:0] refBcd(input int v);
        logic [11:0] r;
        int          d;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            d = (v / (10 ** i)) % 10;
            r[i*4 +: 4] = d[3:0];
        end
        return r;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Protocol model: counts edges since the operand was taken.
    bit          mActive;
    int          mSince;
    int          mOperand;
    logic [11:0] mBcd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mActive = 0;
            mSince  = 0;
            mBcd    = '0;
        end else if (start && (!mActive || mSince == W)) begin
            mActive  = 1;
            mSince   = 0;
            mOperand = int'(bin_in);
        end else if (mActive) begin
            mSince++;
            if (mSince == W) mBcd = refBcd(mOperand);
            if (mSince > W) mActive = 0;
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        check("busy", int'(busy), int'(mActive && mSince < W));
        check("done", int'(done), int'(mActive && mSince == W));
        check("bcd_out", int'(bcd_out), int'(mBcd));
    end

    // Wait for done with a bound; n counts falling edges after the start was driven.
    task automatic waitDone(output int n, output int busyCycles);
        n = 0;
        busyCycles = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) busyCycles++;
        end while (!done && n < 40);
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic convert(input int v, input logic [11:0] exp, input string nm);
        int n, bc;
        start  = 1'b1;
        bin_in = v[7:0];
        @(negedge clk);
        start = 1'b0;
        n = 1;
        bc = busy ? 1 : 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (busy) bc++;
        end
        if (!done) check({nm, "_timeout"}, 0, 1);
        check({nm, "_latency"}, n, 9);
        check({nm, "_busycycles"}, bc, 8);
        check(nm, int'(bcd_out), int'(exp));
        @(negedge clk);
        check({nm, "_donepulse"}, int'(done), 0);
    endtask

    initial begin
        int n, bc, pulses;
        vectors     = 0;
        miscompares = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;

        // Model pinned by hand-computed values.
        check("ref255", int'(refBcd(255)), 'h255);
        check("ref7", int'(refBcd(7)), 'h007);
        check("ref190", int'(refBcd(190)), 'h190);

        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_bcd", int'(bcd_out), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero operand straight after reset release.
        convert(0, 12'h000, "zero");
        convert(255, 12'h255, "v255");
        convert(128, 12'h128, "v128");
        convert(99, 12'h099, "v99");

        // All operands against the arithmetic reference.
        for (int v = 0; v < 256; v++) begin
            convert(v, refBcd(v), "sweep");
        end

        // Start during SHIFT is ignored.
        start  = 1'b1;
        bin_in = 8'd200;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start  = 1'b1;
        bin_in = 8'd17;
        @(negedge clk);
        start = 1'b0;
        waitDone(n, bc);
        check("ignore_result", int'(bcd_out), 'h200);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("ignore_noSecond", pulses, 0);
        check("ignore_hold", int'(bcd_out), 'h200);

        // Start held high: back-to-back conversions.
        start  = 1'b1;
        bin_in = 8'd45;
        @(negedge clk);
        bin_in = 8'd67;
        waitDone(n, bc);
        check("b2b_first", int'(bcd_out), 'h045);
        @(negedge clk);
        check("b2b_busyAgain", int'(busy), 1);
        start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_spacing", n, 9);
        check("b2b_second", int'(bcd_out), 'h067);
        @(negedge clk);
        @(negedge clk);

        // Reset in the middle of a conversion.
        start  = 1'b1;
        bin_in = 8'd150;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_bcd", int'(bcd_out), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_noDone", pulses, 0);
        convert(9, 12'h009, "afterReset");

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
